// File: rtl/jrx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jrx_pkg
//  Brief    : Shared state encoding and widths for the JESD receive link
//             controller (jrx_link_ctrl and its LEMC alignment helper).
//  Revision : 1.0  initial release
// ============================================================================
package jrx_pkg;

    localparam int c_state_w = 3;

    // Link bring-up states; encodings are visible on the debug state port
    typedef enum logic [c_state_w-1:0] {
        c_st_idle    = 3'd0,
        c_st_wait_sr = 3'd1,
        c_st_cgs     = 3'd2,
        c_st_align   = 3'd3,
        c_st_data    = 3'd4,
        c_st_resync  = 3'd5
    } jrx_state_e;

endpackage : jrx_pkg
`default_nettype wire

// File: rtl/jrx_lemc_align.sv
`default_nettype none
// ============================================================================
//  Module   : jrx_lemc_align
//  Brief    : Sysref rising-edge detection with oneshot gating, local
//             multiframe (LEMC) counter alignment and boundary pulse.
//  Revision : 1.0  initial release
// ============================================================================
module jrx_lemc_align
    import jrx_pkg::*;
#(
    parameter int LEMC_PERIOD = 16,
    parameter int LEMC_W      = $clog2(LEMC_PERIOD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sysref_i,
    input  logic              cfg_sysref_disable_i,
    input  logic              cfg_sysref_oneshot_i,
    input  logic [LEMC_W-1:0] cfg_lemc_offset_i,
    input  logic              rearm_i,
    output logic              lemc_o,
    output logic              misalign_o,
    output logic              sr_acc_q_o
);

    logic              sysref_d_q;
    logic              armed_q;
    logic              sr_acc_q;
    logic [LEMC_W-1:0] cnt_q;

    logic              w_rise;
    logic              w_acc;
    logic [LEMC_W-1:0] w_cnt_inc;

    // A rise realigns only when sysref is enabled and, in oneshot mode, the
    // arm flag has not yet been consumed since the last link restart
    assign w_rise     = sysref_i & ~sysref_d_q;
    assign w_acc      = w_rise & ~cfg_sysref_disable_i & (~cfg_sysref_oneshot_i | armed_q);
    assign w_cnt_inc  = cnt_q + LEMC_W'(1);
    assign misalign_o = w_acc & (w_cnt_inc != cfg_lemc_offset_i);
    assign lemc_o     = (cnt_q == LEMC_W'(LEMC_PERIOD - 1));
    assign sr_acc_q_o = sr_acc_q;

    // Edge history, oneshot arm flag and the free-running/realigned counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sysref_d_q <= 1'b0;
            armed_q    <= 1'b1;
            sr_acc_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sysref_d_q <= sysref_i;
            sr_acc_q   <= w_acc;
            cnt_q      <= w_acc ? cfg_lemc_offset_i : w_cnt_inc;
            if (rearm_i) begin
                armed_q <= 1'b1;
            end else if (w_acc) begin
                armed_q <= 1'b0;
            end
        end
    end

endmodule : jrx_lemc_align
`default_nettype wire

// File: rtl/jrx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jrx_link_ctrl
//  Brief    : Receive-side JESD link bring-up controller. Sequences
//             CGS -> alignment -> data, drives sync back to the transmitter,
//             tracks per-multiframe error bursts and forces resync.
//  Revision : 1.0  initial release
// ============================================================================
module jrx_link_ctrl
    import jrx_pkg::*;
#(
    parameter int LEMC_PERIOD   = 16,
    parameter int LOCK_CYCLES   = 8,
    parameter int ERR_THRESH    = 4,
    parameter int ERR_W         = 4,
    parameter int RESYNC_CYCLES = 32,
    parameter int LEMC_W        = $clog2(LEMC_PERIOD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_reset_done_i,
    input  logic                 sysref_i,
    input  logic                 lane_lock_i,
    input  logic                 lane_err_i,
    input  logic                 cfg_sysref_disable_i,
    input  logic                 cfg_sysref_oneshot_i,
    input  logic [LEMC_W-1:0]    cfg_lemc_offset_i,
    output logic                 sync_o,
    output logic                 lemc_o,
    output logic                 prbs_chk_en_o,
    output logic                 link_up_o,
    output logic                 sysref_err_o,
    output logic [ERR_W-1:0]     err_cnt_o,
    output logic [c_state_w-1:0] state_o
);

    localparam int c_lock_w = $clog2(LOCK_CYCLES + 1);
    localparam int c_tmr_w  = $clog2(RESYNC_CYCLES + 1);

    jrx_state_e          state_q;
    jrx_state_e          state_d;
    logic [c_lock_w-1:0] lock_run_q;
    logic [c_tmr_w-1:0]  timer_q;
    logic [ERR_W-1:0]    err_cnt_q;
    logic                sync_q;
    logic                link_up_q;
    logic                prbs_en_q;
    logic                sysref_err_q;

    logic                w_lemc;
    logic                w_misalign;
    logic                w_sr_acc_q;
    logic [ERR_W:0]      w_err_sum;
    logic [ERR_W-1:0]    w_err_inc;

    jrx_lemc_align #(
        .LEMC_PERIOD (LEMC_PERIOD),
        .LEMC_W      (LEMC_W)
    ) u_lemc_align (
        .clk                  (clk),
        .rst                  (rst),
        .sysref_i             (sysref_i),
        .cfg_sysref_disable_i (cfg_sysref_disable_i),
        .cfg_sysref_oneshot_i (cfg_sysref_oneshot_i),
        .cfg_lemc_offset_i    (cfg_lemc_offset_i),
        .rearm_i              (~rx_reset_done_i),
        .lemc_o               (w_lemc),
        .misalign_o           (w_misalign),
        .sr_acc_q_o           (w_sr_acc_q)
    );

    // Threshold sees this cycle's strobe even when the window clears;
    // the stored count saturates rather than wrapping
    assign w_err_sum = {1'b0, err_cnt_q} + {{ERR_W{1'b0}}, lane_err_i};
    assign w_err_inc = (&err_cnt_q) ? err_cnt_q : w_err_sum[ERR_W-1:0];

    // Next-state selection; losing rx_reset_done overrides everything
    always_comb begin
        state_d = state_q;
        if (!rx_reset_done_i) begin
            state_d = c_st_idle;
        end else begin
            case (state_q)
                c_st_idle: begin
                    state_d = cfg_sysref_disable_i ? c_st_cgs : c_st_wait_sr;
                end
                c_st_wait_sr: begin
                    if (w_sr_acc_q) state_d = c_st_cgs;
                end
                c_st_cgs: begin
                    if (lane_lock_i && (lock_run_q == c_lock_w'(LOCK_CYCLES - 1))) begin
                        state_d = c_st_align;
                    end
                end
                c_st_align: begin
                    if (!lane_lock_i) begin
                        state_d = c_st_cgs;
                    end else if (w_lemc) begin
                        state_d = c_st_data;
                    end
                end
                c_st_data: begin
                    if (!lane_lock_i || (w_err_sum >= (ERR_W + 1)'(ERR_THRESH))) begin
                        state_d = c_st_resync;
                    end
                end
                c_st_resync: begin
                    if (timer_q == c_tmr_w'(RESYNC_CYCLES - 1)) state_d = c_st_cgs;
                end
                default: state_d = c_st_idle;
            endcase
        end
    end

    // State, run/timer/error counters and outputs registered from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_idle;
            lock_run_q   <= '0;
            timer_q      <= '0;
            err_cnt_q    <= '0;
            sync_q       <= 1'b0;
            link_up_q    <= 1'b0;
            prbs_en_q    <= 1'b0;
            sysref_err_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == c_st_cgs) && (state_d == c_st_cgs) && lane_lock_i) begin
                lock_run_q <= lock_run_q + c_lock_w'(1);
            end else begin
                lock_run_q <= '0;
            end

            if ((state_q == c_st_resync) && (state_d == c_st_resync)) begin
                timer_q <= timer_q + c_tmr_w'(1);
            end else begin
                timer_q <= '0;
            end

            if ((state_q == c_st_data) && (state_d == c_st_data)) begin
                err_cnt_q <= w_lemc ? '0 : w_err_inc;
            end else begin
                err_cnt_q <= '0;
            end

            sync_q       <= (state_d == c_st_data);
            link_up_q    <= (state_d == c_st_data);
            prbs_en_q    <= (state_d == c_st_data);
            sysref_err_q <= w_misalign && (state_q == c_st_data) && rx_reset_done_i;
        end
    end

    // Sync request must reach the transmitter as soon as reset asserts
    assign sync_o        = sync_q & ~rst;
    assign lemc_o        = w_lemc;
    assign prbs_chk_en_o = prbs_en_q;
    assign link_up_o     = link_up_q;
    assign sysref_err_o  = sysref_err_q;
    assign err_cnt_o     = err_cnt_q;
    assign state_o       = state_q;

endmodule : jrx_link_ctrl
`default_nettype wire

// File: tb/tb_jrx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jrx_link_ctrl
//  Brief    : Directed self-checking bench for jrx_link_ctrl. Inputs change
//             1 time unit after the rising edge; outputs are read there too.
//             ph is the bench's own idea of the LEMC count after each edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jrx_link_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_reset_done = 1'b0;
    logic       sysref = 1'b0;
    logic       lane_lock = 1'b0;
    logic       lane_err = 1'b0;
    logic       cfg_dis = 1'b0;
    logic       cfg_one = 1'b0;
    logic [3:0] cfg_off = 4'd0;
    logic       sync_w, lemc_w, prbs_w, link_up_w, sysref_err_w;
    logic [3:0] err_cnt_w;
    logic [2:0] state_w;

    int n_checks = 0;
    int n_fail   = 0;
    int ph       = 0;

    jrx_link_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_reset_done_i      (rx_reset_done),
        .sysref_i             (sysref),
        .lane_lock_i          (lane_lock),
        .lane_err_i           (lane_err),
        .cfg_sysref_disable_i (cfg_dis),
        .cfg_sysref_oneshot_i (cfg_one),
        .cfg_lemc_offset_i    (cfg_off),
        .sync_o               (sync_w),
        .lemc_o               (lemc_w),
        .prbs_chk_en_o        (prbs_w),
        .link_up_o            (link_up_w),
        .sysref_err_o         (sysref_err_w),
        .err_cnt_o            (err_cnt_w),
        .state_o              (state_w)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 16;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_phase(input int p);
        while (ph != p) tick();
    endtask

    // One-cycle sysref pulse; accept says whether the LEMC count should load off
    task automatic sr_pulse(input logic [3:0] off, input bit accept);
        cfg_off = off;
        sysref  = 1'b1;
        tick();
        if (accept) ph = off;
        sysref  = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state_w != s; i++) tick();
        check_eq(tag, state_w, s);
    endtask

    initial begin
        // Reset values
        #1;
        check_eq("rst_sync", sync_w, 0);
        check_eq("rst_state", state_w, 0);
        check_eq("rst_linkup", link_up_w, 0);
        check_eq("rst_errcnt", err_cnt_w, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_reset_done = 1'b1;
        ph = 0;

        // 1: sysref alignment and bring-up to DATA
        tick();
        check_eq("t1_wait_sr", state_w, 1);
        tick_n(4);
        sr_pulse(4'd0, 1'b1);
        check_eq("t1_still_wait", state_w, 1);
        check_eq("t1_no_lemc", lemc_w, 0);
        tick();
        check_eq("t1_cgs", state_w, 2);
        lane_lock = 1'b1;
        tick_n(7);
        check_eq("t1_cgs_7lock", state_w, 2);
        tick();
        check_eq("t1_align", state_w, 3);
        wait_phase(15);
        check_eq("t1_lemc", lemc_w, 1);
        check_eq("t1_sync_low", sync_w, 0);
        tick();
        check_eq("t1_data", state_w, 4);
        check_eq("t1_sync", sync_w, 1);
        check_eq("t1_linkup", link_up_w, 1);
        check_eq("t1_prbs", prbs_w, 1);

        // 2: three errors stay in DATA, window clears, four errors resync
        lane_err = 1'b1;
        tick_n(3);
        lane_err = 1'b0;
        check_eq("t2_err3", err_cnt_w, 3);
        check_eq("t2_stay", state_w, 4);
        wait_phase(15);
        tick();
        check_eq("t2_win_clr", err_cnt_w, 0);
        lane_err = 1'b1;
        tick_n(3);
        check_eq("t2_err3b", err_cnt_w, 3);
        tick();
        lane_err = 1'b0;
        check_eq("t2_resync", state_w, 5);
        check_eq("t2_sync0", sync_w, 0);
        check_eq("t2_errclr", err_cnt_w, 0);
        tick_n(31);
        check_eq("t2_resync31", state_w, 5);
        tick();
        check_eq("t2_cgs", state_w, 2);
        wait_state("t2_data", 3'd4, 60);

        // 3: misaligned sysref in DATA flags an error and realigns
        wait_phase(5);
        sr_pulse(4'd0, 1'b1);
        check_eq("t3_sr_err", sysref_err_w, 1);
        check_eq("t3_linkup", link_up_w, 1);
        check_eq("t3_state", state_w, 4);
        tick();
        check_eq("t3_sr_err_clr", sysref_err_w, 0);
        wait_phase(15);
        check_eq("t3_lemc_realign", lemc_w, 1);
        sr_pulse(4'd0, 1'b1);
        check_eq("t3_aligned_noerr", sysref_err_w, 0);

        // 4: oneshot ignores the second rise until the link restarts
        cfg_one   = 1'b1;
        lane_lock = 1'b0;
        rx_reset_done = 1'b0;
        tick();
        check_eq("t4_idle", state_w, 0);
        check_eq("t4_sync0", sync_w, 0);
        rx_reset_done = 1'b1;
        tick();
        check_eq("t4_wait_sr", state_w, 1);
        sr_pulse(4'd3, 1'b1);
        tick();
        check_eq("t4_cgs", state_w, 2);
        sr_pulse(4'd7, 1'b0);
        wait_phase(15);
        check_eq("t4_no_realign", lemc_w, 1);
        rx_reset_done = 1'b0;
        tick();
        rx_reset_done = 1'b1;
        tick();
        check_eq("t4_wait_sr2", state_w, 1);
        sr_pulse(4'd7, 1'b1);
        tick();
        check_eq("t4_cgs2", state_w, 2);
        wait_phase(15);
        check_eq("t4_rearmed_lemc", lemc_w, 1);

        // 5: lock loss in ALIGN; lock loss plus error in DATA resyncs once
        cfg_one   = 1'b0;
        lane_lock = 1'b1;
        wait_state("t5_align", 3'd3, 20);
        lane_lock = 1'b0;
        tick();
        check_eq("t5_back_cgs", state_w, 2);
        lane_lock = 1'b1;
        wait_state("t5_data", 3'd4, 60);
        lane_lock = 1'b0;
        lane_err  = 1'b1;
        tick();
        lane_err  = 1'b0;
        check_eq("t5_resync", state_w, 5);
        tick_n(31);
        check_eq("t5_resync31", state_w, 5);
        tick();
        check_eq("t5_cgs", state_w, 2);

        // 6: async reset from DATA, then sysref-disabled restart
        lane_lock = 1'b1;
        wait_state("t6_data", 3'd4, 60);
        wait_phase(0);
        lane_err = 1'b1;
        tick_n(2);
        lane_err = 1'b0;
        check_eq("t6_err2", err_cnt_w, 2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_sync", sync_w, 0);
        check_eq("t6_linkup", link_up_w, 0);
        check_eq("t6_prbs", prbs_w, 0);
        check_eq("t6_errcnt", err_cnt_w, 0);
        check_eq("t6_state", state_w, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ph = 0;
        cfg_dis = 1'b1;
        tick();
        check_eq("t6_dis_cgs", state_w, 2);
        sr_pulse(4'd5, 1'b0);
        wait_phase(15);
        check_eq("t6_dis_lemc", lemc_w, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_jrx_link_ctrl
`default_nettype wire
